// File: rtl/dmem_pkt_reader.sv
// Reads a contiguous window of the 256 x 64 data memory and emits it as one
// packet (header word + body words) on the out_data/out_ctrl/out_wr/out_rdy egress.
module dmem_pkt_reader #(
  parameter int          DATA_WIDTH = 64,
  parameter int          CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int          ADDR_WIDTH = 8,
  parameter logic [15:0] HDR_TAG    = 16'hD0D0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] num_words,
  output logic [ADDR_WIDTH-1:0] d_mem_addra,
  input  logic [DATA_WIDTH-1:0] d_mem_out,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_BODY,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   base_q, num_q, addr_q;
  logic [ADDR_WIDTH-1:0]   iss_cnt, snt_cnt;
  logic                    inflight;
  logic                    hold_v;
  logic [DATA_WIDTH-1:0]   hold_d;
  logic                    issue;
  logic                    have_word;
  logic                    last_word;
  logic                    body_xfer;
  logic [63:0]             hdr_word;

  assign d_mem_addra = addr_q;
  assign have_word   = hold_v | inflight;
  assign last_word   = (snt_cnt == (num_q - ONE));
  assign body_xfer   = (state == S_BODY) && out_wr;
  assign hdr_word    = {HDR_TAG, 16'h0, 8'h0, 8'(base_q), 8'h0, 8'(num_q)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    out_wr   = 1'b0;
    out_data = '0;
    out_ctrl = '0;
    issue    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = (num_words == '0) ? S_DONE : S_HDR;
      end
      S_HDR: begin
        busy = 1'b1;
        // base_addr sits on the address bus throughout HDR; it counts as issued
        // only in the cycle the header leaves, so its data lands in BODY.
        if (out_rdy) begin
          out_wr   = 1'b1;
          out_data = DATA_WIDTH'(hdr_word);
          out_ctrl = CTRL_WIDTH'(8'hFF);
          issue    = 1'b1;
          state_n  = S_BODY;
        end
      end
      S_BODY: begin
        busy = 1'b1;
        if (out_rdy && have_word) begin
          out_wr   = 1'b1;
          out_data = hold_v ? hold_d : d_mem_out;
          out_ctrl = last_word ? CTRL_WIDTH'(8'h80) : CTRL_WIDTH'(8'h00);
          if (last_word) state_n = S_DONE;
        end
        // Next read only when every buffered word drains this cycle, so the
        // returning data always has the holding register free.
        if ((iss_cnt != num_q) && (!have_word || (out_wr && !(hold_v && inflight))))
          issue = 1'b1;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q   <= '0;
      num_q    <= '0;
      addr_q   <= '0;
      iss_cnt  <= '0;
      snt_cnt  <= '0;
      inflight <= 1'b0;
      hold_v   <= 1'b0;
      hold_d   <= '0;
    end else begin
      inflight <= issue;
      if (state == S_IDLE && start) begin
        base_q  <= base_addr;
        num_q   <= num_words;
        addr_q  <= base_addr;
        iss_cnt <= '0;
        snt_cnt <= '0;
      end else if (issue) begin
        addr_q  <= addr_q + ONE;
        iss_cnt <= iss_cnt + ONE;
      end
      if (body_xfer) snt_cnt <= snt_cnt + ONE;
      if (hold_v) begin
        if (body_xfer) begin
          hold_v <= inflight;
          hold_d <= d_mem_out;
        end
      end else if (inflight && !body_xfer) begin
        hold_v <= 1'b1;
        hold_d <= d_mem_out;
      end
    end
  end

endmodule

// File: tb/tb_dmem_pkt_reader.sv
// Scoreboard bench for dmem_pkt_reader: stimulus queues expected packet words,
// a negedge monitor pops and compares every word the DUT writes.
module tb_dmem_pkt_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr, num_words;
  logic [7:0]  d_mem_addra;
  logic [63:0] d_mem_out = '0;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr, out_rdy, busy, done;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  ctrl;
  } word_t;

  word_t       sb[$];
  logic [63:0] mem[256];
  int          checks = 0;
  int          errors = 0;
  int          wr_count = 0;
  logic        prev_v = 1'b0, prev_busy = 1'b0, prev_rdy = 1'b0;
  logic [7:0]  prev_addr = '0;

  always #5 clk = ~clk;

  always @(posedge clk) d_mem_out <= mem[d_mem_addra];

  dmem_pkt_reader #(
    .DATA_WIDTH(64),
    .CTRL_WIDTH(8),
    .ADDR_WIDTH(8),
    .HDR_TAG   (16'hD0D0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .num_words  (num_words),
    .d_mem_addra(d_mem_addra),
    .d_mem_out  (d_mem_out),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .out_wr     (out_wr),
    .out_rdy    (out_rdy),
    .busy       (busy),
    .done       (done)
  );

  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (out_wr) begin
        wr_count++;
        checks++;
        if (out_rdy !== 1'b1) begin
          errors++;
          $display("FAIL wr_without_rdy actual out_rdy=%b required 1", out_rdy);
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word actual data=%h ctrl=%h required no word", out_data, out_ctrl);
        end else begin
          word_t e;
          e = sb.pop_front();
          if (out_data !== e.data || out_ctrl !== e.ctrl) begin
            errors++;
            $display("FAIL pkt_word actual data=%h ctrl=%h required data=%h ctrl=%h",
                     out_data, out_ctrl, e.data, e.ctrl);
          end
        end
      end
      if (prev_v && prev_busy && busy && !prev_rdy) begin
        checks++;
        if (d_mem_addra !== prev_addr) begin
          errors++;
          $display("FAIL addr_stall_hold actual=%h required=%h", d_mem_addra, prev_addr);
        end
      end
      prev_v    = 1'b1;
      prev_busy = busy;
      prev_rdy  = out_rdy;
      prev_addr = d_mem_addra;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic [7:0] c);
    word_t w;
    w.data = d;
    w.ctrl = c;
    sb.push_back(w);
  endtask

  task automatic req(input logic [7:0] b, input logic [7:0] n);
    base_addr = b;
    num_words = n;
    start     = 1'b1;
  endtask

  // Runs from the start cycle until done is seen; toggle applies the
  // 1,0,0,1,0,1,... out_rdy pattern counted from the start cycle.
  task automatic wait_done(input string name, input int maxc, input bit toggle);
    int  c;
    bit  seen;
    c    = 0;
    seen = 1'b0;
    while (!seen && c < maxc) begin
      tick();
      c++;
      start = 1'b0;
      if (toggle) out_rdy = (c >= 3) ? c[0] : 1'b0;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout actual=no done required done within %0d cycles", name, maxc);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] exp_busy, exp_wr, exp_done;
    for (int unsigned a = 0; a < 256; a++) mem[a] = 64'hBEEF_0000_0000_0000 | 64'(a);
    mem[4] = 64'hA;
    mem[5] = 64'hB;
    mem[6] = 64'hC;

    reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; out_rdy = 1'b1;
    tick(); tick();
    chk("reset_ctl", {45'h0, d_mem_addra, out_ctrl, out_wr, busy, done}, 64'h0);
    chk("reset_data", out_data, 64'h0);
    reset = 1'b0;
    tick();

    // Basic packet, cycle-exact
    exp_busy = 5'b01111; exp_wr = 5'b01111; exp_done = 5'b10000;
    push(64'hD0D0_0000_0004_0003, 8'hFF);
    push(64'hA, 8'h00); push(64'hB, 8'h00); push(64'hC, 8'h80);
    req(8'd4, 8'd3);
    for (int k = 0; k < 5; k++) begin
      tick();
      start = 1'b0;
      @(negedge clk);
      chk($sformatf("basic_busy_c%0d", k + 1), {63'h0, busy}, {63'h0, exp_busy[k]});
      chk($sformatf("basic_wr_c%0d", k + 1), {63'h0, out_wr}, {63'h0, exp_wr[k]});
      chk($sformatf("basic_done_c%0d", k + 1), {63'h0, done}, {63'h0, exp_done[k]});
    end
    tick();

    // Same request under out_rdy stalls
    wr_count = 0;
    push(64'hD0D0_0000_0004_0003, 8'hFF);
    push(64'hA, 8'h00); push(64'hB, 8'h00); push(64'hC, 8'h80);
    out_rdy = 1'b1;
    req(8'd4, 8'd3);
    wait_done("stall", 40, 1'b1);
    chk("stall_wr_count", 64'(wr_count), 64'd4);
    out_rdy = 1'b1;
    tick();

    // Address wrap FE,FF,00,01
    push(64'hD0D0_0000_00FE_0004, 8'hFF);
    push(64'hBEEF_0000_0000_00FE, 8'h00); push(64'hBEEF_0000_0000_00FF, 8'h00);
    push(64'hBEEF_0000_0000_0000, 8'h00); push(64'hBEEF_0000_0000_0001, 8'h80);
    req(8'hFE, 8'd4);
    wait_done("wrap", 20, 1'b0);
    tick();

    // num_words = 0: no packet, done next cycle, busy never set
    req(8'd4, 8'd0);
    @(negedge clk);
    chk("zero_busy_c0", {63'h0, busy}, 64'h0);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("zero_done", {63'h0, done}, 64'h1);
    chk("zero_busy", {63'h0, busy}, 64'h0);
    chk("zero_wr", {63'h0, out_wr}, 64'h0);
    tick();
    @(negedge clk);
    chk("zero_done_clear", {63'h0, done}, 64'h0);
    tick();

    // num_words = 1, with a second start while busy
    push(64'hD0D0_0000_0004_0001, 8'hFF);
    push(64'hA, 8'h80);
    req(8'd4, 8'd1);
    tick();
    req(8'h20, 8'd2);
    wait_done("one", 20, 1'b0);
    // start during DONE must be ignored; the one after is taken
    req(8'h10, 8'd2);
    tick();
    push(64'hD0D0_0000_0005_0002, 8'hFF);
    push(64'hB, 8'h00); push(64'hC, 8'h80);
    req(8'd5, 8'd2);
    wait_done("after_done", 20, 1'b0);
    tick();
    chk("sb_drained_mid", 64'(sb.size()), 64'd0);

    // Asynchronous reset after header + first body word
    push(64'hD0D0_0000_0004_0003, 8'hFF);
    push(64'hA, 8'h00);
    req(8'd4, 8'd3);
    tick(); start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("mid_reset_ctl", {45'h0, d_mem_addra, out_ctrl, out_wr, busy, done}, 64'h0);
    chk("mid_reset_data", out_data, 64'h0);
    chk("pre_reset_words", 64'(sb.size()), 64'd0);
    #3;
    reset = 1'b0;
    tick();
    push(64'hD0D0_0000_00FE_0002, 8'hFF);
    push(64'hBEEF_0000_0000_00FE, 8'h00); push(64'hBEEF_0000_0000_00FF, 8'h80);
    req(8'hFE, 8'd2);
    wait_done("post_reset", 20, 1'b0);
    tick();
    chk("sb_drained_end", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_pkt_reader.md
Name: dmem_pkt_reader

Overview:
- Read-back engine for the processor's 256 x 64 data memory. It is the reader counterpart to the d_mem write port and the packet ingress path.
- On a start pulse it reads a contiguous window of data memory and emits it as one NetFPGA-style packet: one header word, then the body words.
- It drives the same out_data/out_ctrl/out_wr/out_rdy handshake as the packet FIFO egress, so it can share the output arbiter.

Parameters:
DATA_WIDTH, 64, width of out_data and of a data-memory word
CTRL_WIDTH, DATA_WIDTH/8, width of out_ctrl
ADDR_WIDTH, 8, data-memory address width
HDR_TAG, 16'hD0D0, tag placed in header bits [63:48]

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  single-cycle request; sampled only in IDLE
base_addr  in  ADDR_WIDTH  first data-memory address to read
num_words  in  ADDR_WIDTH  number of body words (0 = no packet)
d_mem_addra  out  ADDR_WIDTH  data-memory read address
d_mem_out  in  DATA_WIDTH  read data, valid one clk after d_mem_addra
out_data  out  DATA_WIDTH  packet word
out_ctrl  out  CTRL_WIDTH  8'hFF header, 8'h00 body, 8'h80 last body word
out_wr  out  1  word valid/transfer strobe
out_rdy  in  1  downstream can accept a word this cycle
busy  out  1  high from accepted start until the last word transfers
done  out  1  one-cycle pulse after the last word transfers, or after a num_words=0 request

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0 (d_mem_addra, out_data, out_ctrl, out_wr, busy, done).
  - Reset mid-packet truncates the packet with no EOP word; downstream drops it.
- Handshake: out_wr=1 only in a cycle where out_rdy=1. A word counts as transferred in exactly that cycle.
  - out_data/out_ctrl are don't-care when out_wr=0.
  - No word is ever duplicated or skipped across out_rdy stalls of any length.
- Start capture: in IDLE, start=1 latches base_addr and num_words, and sets busy=1 next cycle. start is ignored while busy.
  - num_words=0: no packet; done=1 the next cycle; busy stays 0.
- States:
  - IDLE: wait for start.
  - HDR: present the header word:
    - out_ctrl=8'hFF
    - out_data={HDR_TAG, 16'h0, 8'h0, base_addr, 8'h0, num_words}
    - in bit order [63:48],[47:32],[31:24],[23:16],[15:8],[7:0].
    - Issue d_mem_addra=base_addr in this state (prefetch).
  - BODY: emit word i (0..num_words-1) = d_mem[(base_addr+i) mod 256].
    - out_ctrl=8'h00 for i<num_words-1; 8'h80 for i=num_words-1 (also when num_words=1).
  - DONE: pulse done=1 for one cycle, clear busy, return to IDLE. A start in this cycle is ignored.
- Memory pipeline:
  - One-cycle read latency.
  - A one-entry holding register (plus the in-flight read) covers out_rdy deassertion.
  - The next address is issued only when its data is guaranteed a slot.
  - d_mem_addra holds its value while stalled.
- Address arithmetic: an 8-bit counter that wraps 8'hFF -> 8'h00 with no error.
- Latency, with out_rdy held high and start in cycle 0:
  - header transfers in cycle 1;
  - body word i transfers in cycle 2+i;
  - done in cycle num_words+2;
  - one word per cycle, no bubbles.
- out_rdy low during the header: HDR holds the header and the prefetch stays valid; the header transfers on the first cycle out_rdy=1.

Test Plan:
- d_mem[4..6]=64'hA,B,C; start with base=4, num=3, out_rdy=1 -> header 8'hFF/{D0D0,0,0,04,0,03} at cycle 1; body A,B,C at cycles 2-4 with ctrl 00,00,80; done at cycle 5; busy high cycles 1-4.
- Same request, out_rdy toggling 1,0,0,1,0,1,... -> exactly 4 out_wr pulses, in-order header,A,B,C, each only when out_rdy=1; d_mem_addra stable while stalled.
- base=8'hFE, num=4 -> body reads addresses FE,FF,00,01 in that order; last ctrl 8'h80.
- num=0 -> out_wr never asserted; done=1 the cycle after start; busy=0 throughout. num=1 -> header, then a single body word with ctrl 8'h80.
- start pulsed again while busy -> ignored; exactly one packet emitted. A start in the DONE cycle is ignored; a start the next cycle is accepted.
- Assert reset after header + 1 body word -> all outputs 0 immediately (asynchronous); a fresh start afterwards produces a complete, correct packet.
